// File: rtl/fdiv_seq.sv
// fdiv_seq: iterative single-precision divider (out = a / b).
// Restoring radix-2 division, one quotient bit per clock, with a start/busy/done
// handshake. Truncation rounding, no denormals, canonical QNaN 0x7FC00000.
module fdiv_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] out
);

    localparam int unsigned REM_W = 26;
    localparam int unsigned DIV_W = 24;
    localparam int unsigned Q_W   = 25;
    localparam int unsigned EXP_W = 10;
    localparam int unsigned CNT_W = 5;

    localparam logic [31:0]      QNAN      = 32'h7FC0_0000;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(24);

    typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

    state_t             state, state_n;
    logic [REM_W-1:0]   rem, rem_n;
    logic [DIV_W-1:0]   div_r, div_n;
    logic [Q_W-1:0]     q, q_n;
    logic               sign, sign_n;
    logic [EXP_W-1:0]   exp_r, exp_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [31:0]        out_n;
    logic               busy_n, done_n;

    logic               spec_hit;
    logic [31:0]        spec_val;
    logic [EXP_W-1:0]   norm_e;
    logic [22:0]        norm_mant;
    logic [31:0]        norm_val;

    // Special-operand classification of the incoming operands
    always_comb begin
        logic a_ff, b_ff, a_mnz, b_mnz, a_zero, b_zero, s;
        spec_hit = 1'b0;
        spec_val = 32'h0;
        a_ff   = (a[30:23] == 8'hFF);
        b_ff   = (b[30:23] == 8'hFF);
        a_mnz  = (a[22:0] != 23'd0);
        b_mnz  = (b[22:0] != 23'd0);
        a_zero = (a[30:0] == 31'd0);
        b_zero = (b[30:0] == 31'd0);
        s      = a[31] ^ b[31];
        if ((a_ff && a_mnz) || (b_ff && b_mnz)) begin
            spec_hit = 1'b1;
            spec_val = QNAN;
        end else if ((a_ff && b_ff) || (a_zero && b_zero)) begin
            spec_hit = 1'b1;
            spec_val = QNAN;
        end else if (a_ff || b_zero) begin
            spec_hit = 1'b1;
            spec_val = {s, 8'hFF, 23'd0};
        end else if (a_zero || b_ff) begin
            spec_hit = 1'b1;
            spec_val = {s, 31'd0};
        end
    end

    // Normalisation of the 25-bit quotient with range clamping
    always_comb begin
        norm_e    = q[24] ? exp_r : exp_r - EXP_W'(1);
        norm_mant = q[24] ? q[23:1] : q[22:0];
        if ($signed(norm_e) > 10'sd254) begin
            norm_val = {sign, 8'hFF, 23'd0};
        end else if ($signed(norm_e) < 10'sd1) begin
            norm_val = {sign, 31'd0};
        end else begin
            norm_val = {sign, norm_e[7:0], norm_mant};
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_n = state;
        rem_n   = rem;
        div_n   = div_r;
        q_n     = q;
        sign_n  = sign;
        exp_n   = exp_r;
        cnt_n   = cnt;
        out_n   = out;
        case (state)
            IDLE: begin
                if (start) begin
                    if (spec_hit) begin
                        out_n   = spec_val;
                        state_n = DONE;
                    end else begin
                        rem_n   = REM_W'({1'b0, 1'b1, a[22:0]});
                        div_n   = {1'b1, b[22:0]};
                        q_n     = '0;
                        sign_n  = a[31] ^ b[31];
                        exp_n   = EXP_W'({2'b00, a[30:23]}) - EXP_W'({2'b00, b[30:23]})
                                  + EXP_W'(127);
                        cnt_n   = LAST_ITER;
                        state_n = DIV;
                    end
                end
            end
            DIV: begin
                if (rem >= REM_W'(div_r)) begin
                    q_n   = {q[23:0], 1'b1};
                    rem_n = REM_W'((rem - REM_W'(div_r)) << 1);
                end else begin
                    q_n   = {q[23:0], 1'b0};
                    rem_n = REM_W'(rem << 1);
                end
                cnt_n = cnt - CNT_W'(1);
                if (cnt == CNT_W'(0)) begin
                    state_n = NORM;
                end
            end
            NORM: begin
                out_n   = norm_val;
                state_n = DONE;
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        busy_n = (state_n != IDLE);
        done_n = (state_n == DONE);
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rem   <= '0;
            div_r <= '0;
            q     <= '0;
            sign  <= 1'b0;
            exp_r <= '0;
            cnt   <= '0;
            out   <= 32'h0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            rem   <= rem_n;
            div_r <= div_n;
            q     <= q_n;
            sign  <= sign_n;
            exp_r <= exp_n;
            cnt   <= cnt_n;
            out   <= out_n;
            busy  <= busy_n;
            done  <= done_n;
        end
    end

endmodule

// File: tb/tb_fdiv_seq.sv
// Directed self-checking bench for fdiv_seq.
module tb_fdiv_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] out;

    int checks   = 0;
    int failures = 0;

    fdiv_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            failures++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp_v);
        end
    endtask

    // Issue one divide; exp_edge is the edge index (accepting edge = 0) on which done rises
    task automatic do_div(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] exp_out, input int exp_edge);
        int edge_n;
        a     = av;
        b     = bv;
        start = 1'b1;
        tick();
        edge_n = 0;
        start  = 1'b0;
        a      = 32'hDEAD_BEEF;
        b      = 32'h1234_5678;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        while (!done && edge_n < 40) begin
            tick();
            edge_n++;
        end
        chk({tag, "_lat"}, 32'(edge_n), 32'(exp_edge));
        chk({tag, "_out"}, out, exp_out);
        tick();
        chk({tag, "_done_drop"}, 32'(done), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        chk({tag, "_hold"}, out, exp_out);
    endtask

    initial begin
        int edge_n;
        int n_done;
        int done_edge;
        int unstable;

        // Reset with start asserted: must not be accepted
        rst   = 1'b1;
        start = 1'b1;
        a     = 32'h40C0_0000;
        b     = 32'h4000_0000;
        tick();
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_out", out, 32'h0);
        start = 1'b0;
        rst   = 1'b0;
        tick();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);

        // Normal divides: done on edge E26
        do_div("six_by_two", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 26);
        do_div("one_third", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 26);

        // Special cases: done on the accepting edge E0
        do_div("x_by_negzero", 32'h4000_0000, 32'h8000_0000, 32'hFF80_0000, 0);
        do_div("zero_by_zero", 32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 0);
        do_div("inf_by_inf", 32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000, 0);
        do_div("nan_in", 32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 0);
        do_div("neg_by_inf", 32'hBF80_0000, 32'h7F80_0000, 32'h8000_0000, 0);

        // Range limits
        do_div("overflow", 32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, 26);
        do_div("underflow", 32'h0080_0000, 32'h4000_0000, 32'h0000_0000, 26);

        // start pulses during a divide (cycles 5 and 12) are ignored
        a     = 32'h40C0_0000;
        b     = 32'h4000_0000;
        start = 1'b1;
        tick();
        start     = 1'b0;
        a         = 32'h0;
        b         = 32'h0;
        n_done    = 0;
        done_edge = -1;
        for (int i = 1; i <= 40; i++) begin
            start = (i == 5 || i == 12);
            tick();
            if (done) begin
                n_done++;
                done_edge = i;
            end
        end
        start = 1'b0;
        chk("ignore_ndone", 32'(n_done), 32'd1);
        chk("ignore_edge", 32'(done_edge), 32'd26);
        chk("ignore_out", out, 32'h4040_0000);

        // start held high: re-accepted the cycle after done
        a     = 32'h40C0_0000;
        b     = 32'h4000_0000;
        start = 1'b1;
        tick();
        a      = 32'h3F80_0000;
        b      = 32'h4040_0000;
        edge_n = 0;
        while (!done && edge_n < 40) begin
            tick();
            edge_n++;
        end
        chk("held1_lat", 32'(edge_n), 32'd26);
        chk("held1_out", out, 32'h4040_0000);
        tick();
        chk("held_gap_busy", 32'(busy), 32'd0);
        chk("held_gap_done", 32'(done), 32'd0);
        tick();
        chk("held_reaccept", 32'(busy), 32'd1);
        edge_n   = 0;
        unstable = 0;
        while (!done && edge_n < 40) begin
            if (out !== 32'h4040_0000) unstable++;
            tick();
            edge_n++;
        end
        start = 1'b0;
        chk("held_out_stable", 32'(unstable), 32'd0);
        chk("held2_lat", 32'(edge_n), 32'd26);
        chk("held2_out", out, 32'h3EAA_AAAA);
        tick();
        tick();
        chk("held_stop", 32'(busy), 32'd0);

        // Reset 10 cycles into DIV aborts without a done pulse
        a     = 32'h3F80_0000;
        b     = 32'h4040_0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        tick();
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_out", out, 32'h0);
        chk("abort_done", 32'(done), 32'd0);
        rst    = 1'b0;
        n_done = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done) n_done++;
        end
        chk("abort_no_done", 32'(n_done), 32'd0);
        do_div("after_abort", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 26);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
